// File: rtl/core_pkg.sv
// Shared core widths and the record types used by the ADD issue queue.
package core_pkg;

  localparam int DATA_W = 16;
  localparam int PREG_W = 5;
  localparam int ROB_W  = 5;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] Pw;
    logic [PREG_W-1:0] Pa;
    logic              rdyA;
    logic [DATA_W-1:0] dataA;
    logic [PREG_W-1:0] Pb;
    logic              rdyB;
    logic [DATA_W-1:0] dataB;
    logic [ROB_W-1:0]  tag;
  } iq_entry_t;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] Pw;
    logic [DATA_W-1:0] data;
  } cdb_t;

endpackage

// File: rtl/iq_wakeup_match.sv
// Compares one source tag against every CDB bus; the lowest-index matching bus supplies the value.
module iq_wakeup_match
  import core_pkg::*;
#(
  parameter int N_CDB = 2
) (
  input  logic [PREG_W-1:0]       tag,
  input  logic [N_CDB-1:0]        cdb_valid,
  input  logic [N_CDB*PREG_W-1:0] cdb_Pw,
  input  logic [N_CDB*DATA_W-1:0] cdb_data,
  output logic                    hit,
  output logic [DATA_W-1:0]       data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    // Walk from the highest bus down so the lowest matching index is the last writer.
    for (int i = N_CDB - 1; i >= 0; i--) begin
      if (cdb_valid[i] && (cdb_Pw[i*PREG_W +: PREG_W] == tag)) begin
        hit  = 1'b1;
        data = cdb_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/add_issue_queue.sv
// Age-ordered collapsing issue queue for the ADD unit: CDB wakeup, oldest-ready select,
// registered issue outputs feeding the ADD unit directly.
module add_issue_queue
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int N_CDB = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    freeze_back,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [PREG_W-1:0]       enq_Pw,
  input  logic [PREG_W-1:0]       enq_Pa,
  input  logic                    enq_rdyA,
  input  logic [DATA_W-1:0]       enq_dataA,
  input  logic [PREG_W-1:0]       enq_Pb,
  input  logic                    enq_rdyB,
  input  logic [DATA_W-1:0]       enq_dataB,
  input  logic [ROB_W-1:0]        enq_tag_ROB,
  input  logic [N_CDB-1:0]        cdb_valid,
  input  logic [N_CDB*PREG_W-1:0] cdb_Pw,
  input  logic [N_CDB*DATA_W-1:0] cdb_data,
  output logic                    valid_add,
  output logic [PREG_W-1:0]       Pw_add,
  output logic [DATA_W-1:0]       busA_add,
  output logic [DATA_W-1:0]       busB_add,
  output logic [ROB_W-1:0]        tag_ROB_add,
  output logic [CNT_W-1:0]        count
);

  localparam int IDX_W = $clog2(DEPTH);

  iq_entry_t         q       [DEPTH];
  iq_entry_t         woken   [DEPTH];
  iq_entry_t         q_nxt   [DEPTH];
  logic              hit_a   [DEPTH];
  logic              hit_b   [DEPTH];
  logic [DATA_W-1:0] wdata_a [DEPTH];
  logic [DATA_W-1:0] wdata_b [DEPTH];

  logic              enq_hit_a, enq_hit_b;
  logic [DATA_W-1:0] enq_wdata_a, enq_wdata_b;
  iq_entry_t         enq_entry;
  iq_entry_t         sel_entry;
  logic              sel_valid;
  logic [IDX_W-1:0]  sel_idx;
  logic              do_issue;
  logic              enq_fire;
  logic [CNT_W-1:0]  wr_idx;
  logic [CNT_W-1:0]  count_nxt;

  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    iq_wakeup_match #(.N_CDB(N_CDB)) u_match_a (
      .tag(q[g].Pa), .cdb_valid(cdb_valid), .cdb_Pw(cdb_Pw), .cdb_data(cdb_data),
      .hit(hit_a[g]), .data(wdata_a[g])
    );
    iq_wakeup_match #(.N_CDB(N_CDB)) u_match_b (
      .tag(q[g].Pb), .cdb_valid(cdb_valid), .cdb_Pw(cdb_Pw), .cdb_data(cdb_data),
      .hit(hit_b[g]), .data(wdata_b[g])
    );
  end

  iq_wakeup_match #(.N_CDB(N_CDB)) u_enq_match_a (
    .tag(enq_Pa), .cdb_valid(cdb_valid), .cdb_Pw(cdb_Pw), .cdb_data(cdb_data),
    .hit(enq_hit_a), .data(enq_wdata_a)
  );
  iq_wakeup_match #(.N_CDB(N_CDB)) u_enq_match_b (
    .tag(enq_Pb), .cdb_valid(cdb_valid), .cdb_Pw(cdb_Pw), .cdb_data(cdb_data),
    .hit(enq_hit_b), .data(enq_wdata_b)
  );

  assign enq_ready = (count < CNT_W'(DEPTH));
  assign enq_fire  = enq_valid && enq_ready;

  always_comb begin
    enq_entry       = '0;
    enq_entry.valid = 1'b1;
    enq_entry.Pw    = enq_Pw;
    enq_entry.Pa    = enq_Pa;
    enq_entry.Pb    = enq_Pb;
    enq_entry.tag   = enq_tag_ROB;
    enq_entry.rdyA  = enq_rdyA || enq_hit_a;
    enq_entry.dataA = enq_rdyA ? enq_dataA : enq_wdata_a;
    enq_entry.rdyB  = enq_rdyB || enq_hit_b;
    enq_entry.dataB = enq_rdyB ? enq_dataB : enq_wdata_b;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = q[i];
      if (q[i].valid && !q[i].rdyA && hit_a[i]) begin
        woken[i].rdyA  = 1'b1;
        woken[i].dataA = wdata_a[i];
      end
      if (q[i].valid && !q[i].rdyB && hit_b[i]) begin
        woken[i].rdyB  = 1'b1;
        woken[i].dataB = wdata_b[i];
      end
    end
  end

  // Select works on registered ready bits, so a wakeup this cycle issues next cycle at the earliest.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q[i].valid && q[i].rdyA && q[i].rdyB) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign sel_entry = q[sel_idx];
  assign do_issue  = sel_valid && !freeze_back;
  assign wr_idx    = count - CNT_W'(do_issue);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) q_nxt[i] = woken[i];
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (do_issue && (IDX_W'(i) >= sel_idx)) q_nxt[i] = woken[i+1];
    end
    if (do_issue) q_nxt[DEPTH-1].valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (enq_fire && (CNT_W'(i) == wr_idx)) q_nxt[i] = enq_entry;
    end
  end

  always_comb begin
    count_nxt = count;
    case ({enq_fire, do_issue})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Queue state and issue register stage
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
      count       <= '0;
      valid_add   <= 1'b0;
      Pw_add      <= '0;
      busA_add    <= '0;
      busB_add    <= '0;
      tag_ROB_add <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      count <= count_nxt;
      if (!freeze_back) begin
        valid_add <= sel_valid;
        if (sel_valid) begin
          Pw_add      <= sel_entry.Pw;
          busA_add    <= sel_entry.dataA;
          busB_add    <= sel_entry.dataB;
          tag_ROB_add <= sel_entry.tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_issue_queue.sv
// Directed bench for add_issue_queue: expected issues are queued at stimulus time and popped as they appear.
module tb_add_issue_queue;
  import core_pkg::*;

  localparam int DEPTH = 4;
  localparam int N_CDB = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                    clk = 1'b0;
  logic                    rst, flush, freeze_back;
  logic                    enq_valid, enq_ready;
  logic [PREG_W-1:0]       enq_Pw, enq_Pa, enq_Pb;
  logic                    enq_rdyA, enq_rdyB;
  logic [DATA_W-1:0]       enq_dataA, enq_dataB;
  logic [ROB_W-1:0]        enq_tag_ROB;
  logic [N_CDB-1:0]        cdb_valid;
  logic [N_CDB*PREG_W-1:0] cdb_Pw;
  logic [N_CDB*DATA_W-1:0] cdb_data;
  logic                    valid_add;
  logic [PREG_W-1:0]       Pw_add;
  logic [DATA_W-1:0]       busA_add, busB_add;
  logic [ROB_W-1:0]        tag_ROB_add;
  logic [CNT_W-1:0]        count;

  add_issue_queue #(.DEPTH(DEPTH), .N_CDB(N_CDB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze_back(freeze_back),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_Pw(enq_Pw),
    .enq_Pa(enq_Pa), .enq_rdyA(enq_rdyA), .enq_dataA(enq_dataA),
    .enq_Pb(enq_Pb), .enq_rdyB(enq_rdyB), .enq_dataB(enq_dataB),
    .enq_tag_ROB(enq_tag_ROB), .cdb_valid(cdb_valid), .cdb_Pw(cdb_Pw),
    .cdb_data(cdb_data), .valid_add(valid_add), .Pw_add(Pw_add),
    .busA_add(busA_add), .busB_add(busB_add), .tag_ROB_add(tag_ROB_add),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PREG_W-1:0] pw;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ROB_W-1:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic frz_q  = 1'b0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq_op(input logic [PREG_W-1:0] pw, input logic [PREG_W-1:0] pa,
                        input logic ra, input logic [DATA_W-1:0] da,
                        input logic [PREG_W-1:0] pb, input logic rb,
                        input logic [DATA_W-1:0] db, input logic [ROB_W-1:0] tag);
    enq_valid = 1'b1; enq_Pw = pw; enq_Pa = pa; enq_rdyA = ra; enq_dataA = da;
    enq_Pb = pb; enq_rdyB = rb; enq_dataB = db; enq_tag_ROB = tag;
  endtask

  task automatic push_exp(input logic [PREG_W-1:0] pw, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input logic [ROB_W-1:0] tag);
    exp_t e;
    e.pw = pw; e.a = a; e.b = b; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic set_cdb(input int bus, input logic [PREG_W-1:0] pw, input logic [DATA_W-1:0] d);
    cdb_valid[bus] = 1'b1;
    cdb_Pw[bus*PREG_W +: PREG_W] = pw;
    cdb_data[bus*DATA_W +: DATA_W] = d;
  endtask

  task automatic clr_cdb();
    cdb_valid = '0; cdb_Pw = '0; cdb_data = '0;
  endtask

  // A held issue register during freeze is not a new issue.
  always @(posedge clk) frz_q <= freeze_back;

  always @(negedge clk) begin
    if (valid_add === 1'b1 && !frz_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_issue observed Pw=%0h tag=%0h expected no issue", Pw_add, tag_ROB_add);
      end else begin
        mon_e = exp_q.pop_front();
        check("iss_Pw", 32'(Pw_add), 32'(mon_e.pw));
        check("iss_busA", 32'(busA_add), 32'(mon_e.a));
        check("iss_busB", 32'(busB_add), 32'(mon_e.b));
        check("iss_tag", 32'(tag_ROB_add), 32'(mon_e.tag));
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; freeze_back = 1'b0; enq_valid = 1'b0;
    enq_Pw = '0; enq_Pa = '0; enq_Pb = '0; enq_rdyA = 1'b0; enq_rdyB = 1'b0;
    enq_dataA = '0; enq_dataB = '0; enq_tag_ROB = '0;
    clr_cdb();
    tick(); tick();
    check("rst_valid", 32'(valid_add), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ready", 32'(enq_ready), 1);
    check("rst_Pw", 32'(Pw_add), 0);
    check("rst_busA", 32'(busA_add), 0);
    check("rst_busB", 32'(busB_add), 0);
    check("rst_tag", 32'(tag_ROB_add), 0);
    rst = 1'b0;
    tick();

    // Ready-at-dispatch op issues one edge after enqueue.
    enq_op(5'd3, 5'd1, 1'b1, 16'd5, 5'd2, 1'b1, 16'd7, 5'd2);
    push_exp(5'd3, 16'd5, 16'd7, 5'd2);
    tick();
    enq_valid = 1'b0;
    check("t1_count1", 32'(count), 1);
    check("t1_not_early", 32'(valid_add), 0);
    tick();
    check("t1_valid", 32'(valid_add), 1);
    check("t1_count0", 32'(count), 0);
    tick();
    check("t1_idle", 32'(valid_add), 0);

    // CDB wakeup of operand A, issue the edge after the wakeup edge.
    enq_op(5'd4, 5'd9, 1'b0, 16'd0, 5'd1, 1'b1, 16'h0011, 5'd3);
    tick();
    enq_valid = 1'b0;
    tick();
    check("t2_wait", 32'(valid_add), 0);
    set_cdb(1, 5'd9, 16'h1234);
    push_exp(5'd4, 16'h1234, 16'h0011, 5'd3);
    tick();
    clr_cdb();
    check("t2_not_early", 32'(valid_add), 0);
    tick();
    check("t2_valid", 32'(valid_add), 1);
    check("t2_busA", 32'(busA_add), 32'h1234);
    check("t2_count", 32'(count), 0);

    // Fill, refuse fifth, age-ordered issue, lowest CDB index wins.
    for (int k = 0; k < 4; k++) begin
      enq_op(5'(8 + k), 5'(10 + k), 1'b0, 16'd0, 5'd1, 1'b1, 16'(16'h0100 + k), 5'(8 + k));
      tick();
    end
    enq_valid = 1'b0;
    check("t3_full_count", 32'(count), 4);
    check("t3_full_ready", 32'(enq_ready), 0);
    enq_op(5'd15, 5'd1, 1'b1, 16'd1, 5'd1, 1'b1, 16'd1, 5'd15);
    tick();
    enq_valid = 1'b0;
    check("t3_refused", 32'(count), 4);
    set_cdb(0, 5'd12, 16'h0C0C);
    set_cdb(1, 5'd10, 16'h0A0A);
    push_exp(5'd8, 16'h0A0A, 16'h0100, 5'd8);
    push_exp(5'd10, 16'h0C0C, 16'h0102, 5'd10);
    tick();
    clr_cdb();
    check("t3_wake_count", 32'(count), 4);
    check("t3_wake_noissue", 32'(valid_add), 0);
    tick();
    check("t3_first_Pw", 32'(Pw_add), 8);
    check("t3_first_count", 32'(count), 3);
    set_cdb(0, 5'd11, 16'h0B0B);
    set_cdb(1, 5'd11, 16'hDEAD);
    push_exp(5'd9, 16'h0B0B, 16'h0101, 5'd9);
    tick();
    clr_cdb();
    check("t3_second_Pw", 32'(Pw_add), 10);
    check("t3_second_count", 32'(count), 2);
    set_cdb(0, 5'd13, 16'h0D0D);
    push_exp(5'd11, 16'h0D0D, 16'h0103, 5'd11);
    tick();
    clr_cdb();
    check("t3_third_Pw", 32'(Pw_add), 9);
    check("t3_third_count", 32'(count), 1);
    tick();
    check("t3_fourth_Pw", 32'(Pw_add), 11);
    check("t3_drained", 32'(count), 0);
    tick();
    check("t3_idle", 32'(valid_add), 0);

    // Same-cycle CDB bypass at enqueue.
    enq_op(5'd5, 5'd2, 1'b1, 16'h0022, 5'd6, 1'b0, 16'd0, 5'd7);
    set_cdb(0, 5'd6, 16'h00AA);
    push_exp(5'd5, 16'h0022, 16'h00AA, 5'd7);
    tick();
    enq_valid = 1'b0;
    clr_cdb();
    tick();
    check("t4_valid", 32'(valid_add), 1);
    check("t4_busB", 32'(busB_add), 32'h00AA);
    check("t4_count", 32'(count), 0);

    // Freeze holds the issue register while enqueue continues.
    enq_op(5'd1, 5'd1, 1'b1, 16'h0001, 5'd1, 1'b1, 16'h0002, 5'd1);
    push_exp(5'd1, 16'h0001, 16'h0002, 5'd1);
    tick();
    enq_op(5'd2, 5'd1, 1'b1, 16'h0003, 5'd1, 1'b1, 16'h0004, 5'd2);
    push_exp(5'd2, 16'h0003, 16'h0004, 5'd2);
    tick();
    check("t5_A_Pw", 32'(Pw_add), 1);
    check("t5_A_count", 32'(count), 1);
    freeze_back = 1'b1;
    enq_op(5'd3, 5'd1, 1'b1, 16'h0005, 5'd1, 1'b1, 16'h0006, 5'd3);
    push_exp(5'd3, 16'h0005, 16'h0006, 5'd3);
    tick();
    enq_valid = 1'b0;
    check("t5_hold1_Pw", 32'(Pw_add), 1);
    check("t5_hold1_valid", 32'(valid_add), 1);
    check("t5_hold1_count", 32'(count), 2);
    tick();
    check("t5_hold2_busA", 32'(busA_add), 1);
    check("t5_hold2_count", 32'(count), 2);
    tick();
    check("t5_hold3_tag", 32'(tag_ROB_add), 1);
    check("t5_hold3_count", 32'(count), 2);
    freeze_back = 1'b0;
    tick();
    check("t5_B_Pw", 32'(Pw_add), 2);
    check("t5_B_count", 32'(count), 1);
    tick();
    check("t5_C_Pw", 32'(Pw_add), 3);
    check("t5_C_count", 32'(count), 0);
    tick();
    check("t5_idle", 32'(valid_add), 0);

    // Flush beats a same-cycle enqueue; later wakeups find nothing.
    for (int k = 0; k < 3; k++) begin
      enq_op(5'(20 + k), 5'(20 + k), 1'b0, 16'd0, 5'd1, 1'b1, 16'd9, 5'(20 + k));
      tick();
    end
    check("t6_count3", 32'(count), 3);
    enq_op(5'd30, 5'd1, 1'b1, 16'd1, 5'd1, 1'b1, 16'd1, 5'd30);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    enq_valid = 1'b0;
    check("t6_flush_count", 32'(count), 0);
    check("t6_flush_valid", 32'(valid_add), 0);
    check("t6_flush_ready", 32'(enq_ready), 1);
    set_cdb(0, 5'd20, 16'h0001);
    tick();
    clr_cdb();
    check("t6_post_valid", 32'(valid_add), 0);
    tick();
    check("t6_post2_valid", 32'(valid_add), 0);
    check("t6_post2_count", 32'(count), 0);

    // Reset arriving on the edge where a ready op would issue.
    enq_op(5'd31, 5'd1, 1'b1, 16'h0077, 5'd1, 1'b1, 16'h0088, 5'd31);
    tick();
    enq_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_valid", 32'(valid_add), 0);
    check("t6_rst_count", 32'(count), 0);
    check("t6_rst_Pw", 32'(Pw_add), 0);
    check("t6_rst_busA", 32'(busA_add), 0);
    tick();
    check("t6_rst_post_valid", 32'(valid_add), 0);
    tick();

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
